// File: rtl/alsu_cmd_seq.sv
// alsu_cmd_seq: command FIFO and repeat sequencer that drives registered ALSU fields.
// Optional build macro ALSU_SEQ_ILLEGAL_FILTER_EN drops opcodes 110/111 and counts them in err_cnt.
`default_nettype none

module alsu_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [15:0]              cmd,
    input  logic [2:0]               cmd_rep,
    output logic [2:0]               A_o,
    output logic [2:0]               B_o,
    output logic [2:0]               opcode_o,
    output logic                     cin_o,
    output logic                     serial_in_o,
    output logic                     direction_o,
    output logic                     red_op_A_o,
    output logic                     red_op_B_o,
    output logic                     bypass_A_o,
    output logic                     bypass_B_o,
    output logic                     issue_vld,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    logic [15:0]      cmd_mem [DEPTH];
    logic [2:0]       rep_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             rdy_en;

    state_t           state, state_nxt;
    logic [2:0]       rem, rem_nxt;
    logic [15:0]      out_q, out_nxt;
    logic             vld_q, vld_nxt;

    logic             push;
    logic             store;
    logic             pop;
    logic             illegal;
    logic             fifo_ne;

    // rdy_en keeps cmd_rdy low throughout reset and for the edge that releases it.
    assign cmd_rdy = rdy_en && (level_q != LVL_W'(DEPTH));
    assign push    = cmd_vld && cmd_rdy;
    assign fifo_ne = (level_q != '0);
    assign level   = level_q;

`ifdef ALSU_SEQ_ILLEGAL_FILTER_EN
    assign illegal = (cmd[9:8] == 2'b11);
`else
    assign illegal = 1'b0;
`endif

    assign store = push && !illegal;

    always_ff @(posedge clk) begin
        if (store) begin
            cmd_mem[wr_ptr] <= cmd;
            rep_mem[wr_ptr] <= cmd_rep;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            level_q <= level_q + LVL_W'(store) - LVL_W'(pop);
            if (store)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rem   <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            out_q <= out_nxt;
            vld_q <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        out_nxt   = out_q;
        vld_nxt   = vld_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_ne) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                    out_nxt   = cmd_mem[rd_ptr];
                    rem_nxt   = rep_mem[rd_ptr];
                    vld_nxt   = 1'b1;
                end
            end
            ISSUE: begin
                if (rem != 3'd0) begin
                    rem_nxt = rem - 3'd1;
                end else if (fifo_ne) begin
                    // Back-to-back: load the next head on the same edge the last repeat ends.
                    pop     = 1'b1;
                    out_nxt = cmd_mem[rd_ptr];
                    rem_nxt = rep_mem[rd_ptr];
                    vld_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    out_nxt   = '0;
                    vld_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                rem_nxt   = '0;
                out_nxt   = '0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    assign {A_o, B_o, opcode_o, cin_o, serial_in_o, direction_o,
            red_op_A_o, red_op_B_o, bypass_A_o, bypass_B_o} = out_q;
    assign issue_vld = vld_q;

`ifdef ALSU_SEQ_ILLEGAL_FILTER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt <= '0;
        else if (push && illegal && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alsu_cmd_seq.sv
// tb_alsu_cmd_seq: directed stimulus with a scoreboard queue of expected issue cycles.
`default_nettype none

module tb_alsu_cmd_seq;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [15:0]      cmd;
    logic [2:0]       cmd_rep;
    logic [2:0]       A_o, B_o, opcode_o;
    logic             cin_o, serial_in_o, direction_o;
    logic             red_op_A_o, red_op_B_o, bypass_A_o, bypass_B_o;
    logic             issue_vld;
    logic [LVL_W-1:0] level;
    logic [7:0]       err_cnt;

    alsu_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd(cmd), .cmd_rep(cmd_rep),
        .A_o(A_o), .B_o(B_o), .opcode_o(opcode_o),
        .cin_o(cin_o), .serial_in_o(serial_in_o), .direction_o(direction_o),
        .red_op_A_o(red_op_A_o), .red_op_B_o(red_op_B_o),
        .bypass_A_o(bypass_A_o), .bypass_B_o(bypass_B_o),
        .issue_vld(issue_vld), .level(level), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    int          run_len    = 0;
    int          last_run   = 0;
    logic [15:0] exp_q[$];

`ifdef ALSU_SEQ_ILLEGAL_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    function automatic logic [15:0] pk(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] op, input logic [6:0] ctl);
        return {a, b, op, ctl};
    endfunction

    function automatic logic [15:0] fields();
        return {A_o, B_o, opcode_o, cin_o, serial_in_o, direction_o,
                red_op_A_o, red_op_B_o, bypass_A_o, bypass_B_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every visible issue cycle must match the oldest outstanding expectation.
    task automatic check_out();
        logic [15:0] exp;
        if (issue_vld === 1'b1) begin
            run_len++;
            chk("sb_expect_pending", (exp_q.size() != 0), 1);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0;
            chk("sb_fields", fields(), exp);
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            chk("idle_fields", {issue_vld, fields()}, 17'h0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_out();
    endtask

    task automatic push(input logic [15:0] c, input logic [2:0] r, output int waited);
        waited  = 0;
        cmd     = c;
        cmd_rep = r;
        cmd_vld = 1'b1;
        while (cmd_rdy !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        chk("push_timeout", (waited < 50), 1);
        if (!(FILTER && c[9:8] == 2'b11))
            for (int i = 0; i <= int'(r); i++) exp_q.push_back(c);
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || issue_vld === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", (n < 100), 1);
    endtask

    initial begin
        int w;
        logic [15:0] c5;
        rst = 1'b0; cmd_vld = 1'b0; cmd = '0; cmd_rep = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy",   cmd_rdy, 0);
        chk("rst_level", level, 0);
        chk("rst_out",   {issue_vld, fields()}, 0);
        chk("rst_err",   err_cnt, 0);
        rst = 1'b1;
        tick();
        chk("rdy_after_rst", cmd_rdy, 1);

        // Single command, one-edge latency, exactly one issue cycle.
        push(pk(3'd5, 3'd1, 3'b011, 7'h00), 3'd0, w);
        chk("lat_not_yet", issue_vld, 0);
        tick();
        chk("lat_issue", issue_vld, 1);
        chk("lat_fields", {A_o, B_o, opcode_o}, {3'd5, 3'd1, 3'b011});
        tick();
        chk("single_drop", issue_vld, 0);
        chk("single_run", last_run, 1);

        // Repeat count 5 gives six consecutive issue cycles.
        push(pk(3'd2, 3'd6, 3'b100, 7'h55), 3'd5, w);
        drain();
        chk("rep5_run", last_run, 6);

        // Three single-shot commands back to back, no gap.
        push(pk(3'd1, 3'd2, 3'b000, 7'h01), 3'd0, w);
        push(pk(3'd3, 3'd4, 3'b001, 7'h02), 3'd0, w);
        push(pk(3'd6, 3'd7, 3'b010, 7'h40), 3'd0, w);
        drain();
        chk("b2b_run", last_run, 3);

        // Fill the FIFO behind a long repeat; fifth push must stall.
        push(pk(3'd7, 3'd7, 3'b101, 7'h7F), 3'd7, w);
        for (int i = 0; i < 4; i++)
            push(pk(3'(i), 3'(i + 1), 3'(i), 7'(i * 9)), 3'd0, w);
        chk("full_level", level, DEPTH);
        chk("full_rdy",   cmd_rdy, 0);
        c5 = pk(3'd4, 3'd3, 3'b011, 7'h2A);
        push(c5, 3'd0, w);
        chk("full_stalled", (w > 0), 1);
        drain();
        chk("full_run", last_run, 13);
        chk("full_empty", level, 0);

        // Opcode 111: dropped and counted when filtered, otherwise issued.
        push(pk(3'd2, 3'd3, 3'b111, 7'h11), 3'd0, w);
        chk("ill_level", level, FILTER ? 0 : 1);
        chk("ill_err",   err_cnt, FILTER ? 1 : 0);
        drain();
        if (FILTER) begin
            for (int i = 0; i < 299; i++)
                push(pk(3'(i), 3'd0, 3'b110 | 3'(i & 1), 7'h0), 3'd0, w);
            drain();
            chk("ill_sat", err_cnt, 255);
            chk("ill_sat_level", level, 0);
        end else begin
            chk("ill_run", last_run, 1);
            chk("ill_err0", err_cnt, 0);
        end

        // Async reset in the middle of a repeat discards everything.
        push(pk(3'd5, 3'd5, 3'b001, 7'h33), 3'd7, w);
        push(pk(3'd1, 3'd1, 3'b010, 7'h0C), 3'd0, w);
        w = 0;
        while (run_len != 3 && w < 20) begin
            tick();
            w++;
        end
        chk("midrst_reach", run_len, 3);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out",   {issue_vld, fields()}, 0);
        chk("midrst_level", level, 0);
        chk("midrst_rdy",   cmd_rdy, 0);
        chk("midrst_err",   err_cnt, 0);
        exp_q.delete();
        run_len = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rdy",   cmd_rdy, 1);
        chk("post_level", level, 0);
        repeat (12) tick();
        chk("post_vld", issue_vld, 0);

        // Recovery after reset.
        push(pk(3'd6, 3'd2, 3'b100, 7'h08), 3'd1, w);
        drain();
        chk("post_run", last_run, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
